// File: rtl/tb_sim_ctrl.sv
// Simulation run controller: sequences core reset and fetch enable, counts run cycles,
// captures the first termination event and raises done_o after a drain window.
// Optional stall watchdog: define TB_SIM_CTRL_STALL_WDOG_EN.
module tb_sim_ctrl #(
   parameter int unsigned RESET_WAIT_CYCLES = 4,
   parameter int unsigned DRAIN_CYCLES      = 8,
   parameter int unsigned CNT_W             = 32
`ifdef TB_SIM_CTRL_STALL_WDOG_EN
   ,
   parameter int unsigned STALL_LIMIT       = 1000
`endif
) (
   input  logic             clk_i,
   input  logic             rst_i,
`ifdef TB_SIM_CTRL_STALL_WDOG_EN
   input  logic             instr_retired_i,
`endif
   input  logic [CNT_W-1:0] max_cycles_i,
   input  logic             tests_passed_i,
   input  logic             tests_failed_i,
   input  logic             exit_valid_i,
   input  logic [31:0]      exit_value_i,
   output logic             core_rst_no,
   output logic             fetch_enable_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [1:0]       status_o,
   output logic [31:0]      exit_code_o,
   output logic             done_o
);

   typedef enum logic [1:0] {HOLD, RUN, DRAIN, DONE} state_t;

   state_t           state_q, state_d;
   logic [31:0]      holdCnt_q, holdCnt_d;
   logic [31:0]      drainCnt_q, drainCnt_d;
   logic             coreRstN_q, coreRstN_d;
   logic             fetchEn_q, fetchEn_d;
   logic [CNT_W-1:0] cycleCnt_q, cycleCnt_d;
   logic [1:0]       status_q, status_d;
   logic [31:0]      exitCode_q, exitCode_d;
   logic             done_q, done_d;
`ifdef TB_SIM_CTRL_STALL_WDOG_EN
   logic [31:0]      stallCnt_q, stallCnt_d;
`endif

   logic             evValid;
   logic [1:0]       evStatus;
   logic [31:0]      evCode;

   // Termination sources in fixed priority order; only consumed while in RUN.
   always_comb begin
      evValid  = 1'b1;
      evStatus = 2'd0;
      evCode   = 32'd0;
      if (tests_failed_i) begin
         evStatus = 2'd2;
         evCode   = 32'd1;
      end else if (exit_valid_i) begin
         evStatus = (exit_value_i == 32'd0) ? 2'd1 : 2'd2;
         evCode   = exit_value_i;
      end else if (tests_passed_i) begin
         evStatus = 2'd1;
         evCode   = 32'd0;
      end else if ((max_cycles_i != '0) && (cycleCnt_q >= max_cycles_i)) begin
         evStatus = 2'd3;
         evCode   = 32'hFFFF_FFFF;
`ifdef TB_SIM_CTRL_STALL_WDOG_EN
      end else if (stallCnt_q >= STALL_LIMIT) begin
         evStatus = 2'd3;
         evCode   = 32'hFFFF_FFFE;
`endif
      end else begin
         evValid = 1'b0;
      end
   end

   always_comb begin
      state_d    = state_q;
      holdCnt_d  = holdCnt_q;
      drainCnt_d = drainCnt_q;
      coreRstN_d = coreRstN_q;
      fetchEn_d  = fetchEn_q;
      cycleCnt_d = cycleCnt_q;
      status_d   = status_q;
      exitCode_d = exitCode_q;
      done_d     = done_q;
`ifdef TB_SIM_CTRL_STALL_WDOG_EN
      stallCnt_d = 32'd0;
`endif
      case (state_q)
         HOLD: begin
            if (holdCnt_q == RESET_WAIT_CYCLES - 1) begin
               coreRstN_d = 1'b1;
               holdCnt_d  = 32'd0;
               state_d    = RUN;
            end else begin
               holdCnt_d = holdCnt_q + 32'd1;
            end
         end
         RUN: begin
            if (evValid) begin
               status_d   = evStatus;
               exitCode_d = evCode;
               fetchEn_d  = 1'b0;
               drainCnt_d = 32'd0;
               if (DRAIN_CYCLES == 0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = DRAIN;
               end
            end else begin
               fetchEn_d = 1'b1;
               if (cycleCnt_q != '1) begin
                  cycleCnt_d = cycleCnt_q + 1'b1;
               end
`ifdef TB_SIM_CTRL_STALL_WDOG_EN
               if (instr_retired_i) begin
                  stallCnt_d = 32'd0;
               end else if (stallCnt_q < STALL_LIMIT) begin
                  stallCnt_d = stallCnt_q + 32'd1;
               end else begin
                  stallCnt_d = stallCnt_q;
               end
`endif
            end
         end
         DRAIN: begin
            fetchEn_d = 1'b0;
            if (drainCnt_q == DRAIN_CYCLES - 1) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               drainCnt_d = drainCnt_q + 32'd1;
            end
         end
         default: begin
            fetchEn_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= HOLD;
         holdCnt_q  <= 32'd0;
         drainCnt_q <= 32'd0;
         coreRstN_q <= 1'b0;
         fetchEn_q  <= 1'b0;
         cycleCnt_q <= '0;
         status_q   <= 2'd0;
         exitCode_q <= 32'd0;
         done_q     <= 1'b0;
`ifdef TB_SIM_CTRL_STALL_WDOG_EN
         stallCnt_q <= 32'd0;
`endif
      end else begin
         state_q    <= state_d;
         holdCnt_q  <= holdCnt_d;
         drainCnt_q <= drainCnt_d;
         coreRstN_q <= coreRstN_d;
         fetchEn_q  <= fetchEn_d;
         cycleCnt_q <= cycleCnt_d;
         status_q   <= status_d;
         exitCode_q <= exitCode_d;
         done_q     <= done_d;
`ifdef TB_SIM_CTRL_STALL_WDOG_EN
         stallCnt_q <= stallCnt_d;
`endif
      end
   end

   assign core_rst_no    = coreRstN_q;
   assign fetch_enable_o = fetchEn_q;
   assign cycle_cnt_o    = cycleCnt_q;
   assign status_o       = status_q;
   assign exit_code_o    = exitCode_q;
   assign done_o         = done_q;

endmodule

// File: tb/tb_tb_sim_ctrl.sv
// Bench for tb_sim_ctrl: directed scenarios plus randomized runs, all checked every cycle
// against a reference model built from elapsed-edge counts and capture age.
module tb_tb_sim_ctrl;

   localparam int unsigned RW = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned CW = 32;
   localparam int unsigned SW = 6;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [CW-1:0] maxCycles = '0;
   logic          testsPassed = 1'b0;
   logic          testsFailed = 1'b0;
   logic          exitValid = 1'b0;
   logic [31:0]   exitValue = 32'd0;
`ifdef TB_SIM_CTRL_STALL_WDOG_EN
   logic          instrRetired = 1'b1;
`endif

   logic          coreRstN, fetchEn, done;
   logic [CW-1:0] cycleCnt;
   logic [1:0]    status;
   logic [31:0]   exitCode;

   logic          smallCoreRstN, smallFetchEn, smallDone;
   logic [SW-1:0] smallCycleCnt;
   logic [1:0]    smallStatus;
   logic [31:0]   smallExitCode;

   int checks = 0;
   int errors = 0;
   bit checkEn = 1'b0;

   tb_sim_ctrl #(.RESET_WAIT_CYCLES(RW), .DRAIN_CYCLES(DW), .CNT_W(CW)) dut (
      .clk_i          (clock),
      .rst_i          (reset),
`ifdef TB_SIM_CTRL_STALL_WDOG_EN
      .instr_retired_i(instrRetired),
`endif
      .max_cycles_i   (maxCycles),
      .tests_passed_i (testsPassed),
      .tests_failed_i (testsFailed),
      .exit_valid_i   (exitValid),
      .exit_value_i   (exitValue),
      .core_rst_no    (coreRstN),
      .fetch_enable_o (fetchEn),
      .cycle_cnt_o    (cycleCnt),
      .status_o       (status),
      .exit_code_o    (exitCode),
      .done_o         (done)
   );

   // Narrow counter instance so saturation is reachable in a short run.
   tb_sim_ctrl #(.RESET_WAIT_CYCLES(RW), .DRAIN_CYCLES(DW), .CNT_W(SW)) dutSmall (
      .clk_i          (clock),
      .rst_i          (reset),
`ifdef TB_SIM_CTRL_STALL_WDOG_EN
      .instr_retired_i(instrRetired),
`endif
      .max_cycles_i   ({SW{1'b0}}),
      .tests_passed_i (1'b0),
      .tests_failed_i (1'b0),
      .exit_valid_i   (1'b0),
      .exit_value_i   (32'd0),
      .core_rst_no    (smallCoreRstN),
      .fetch_enable_o (smallFetchEn),
      .cycle_cnt_o    (smallCycleCnt),
      .status_o       (smallStatus),
      .exit_code_o    (smallExitCode),
      .done_o         (smallDone)
   );

   always #5 clock = ~clock;

   // Reference model state: edges since reset release, capture flag and its age.
   int unsigned   sinceRel = 0;
   bit            captured = 1'b0;
   int unsigned   capAge = 0;
   logic [CW-1:0] mCnt = '0;
   logic [1:0]    mStatus = 2'd0;
   logic [31:0]   mCode = 32'd0;
   bit            evHit;
   logic [1:0]    evSt;
   logic [31:0]   evCd;

   always @(posedge clock) begin
      if (reset) begin
         sinceRel = 0;
         captured = 1'b0;
         capAge   = 0;
         mCnt     = '0;
         mStatus  = 2'd0;
         mCode    = 32'd0;
      end else begin
         if (captured) begin
            if (capAge < 1000) capAge++;
         end else if (sinceRel >= RW) begin
            evHit = 1'b1;
            evSt  = 2'd0;
            evCd  = 32'd0;
            if (testsFailed) begin
               evSt = 2'd2; evCd = 32'd1;
            end else if (exitValid) begin
               evSt = (exitValue == 0) ? 2'd1 : 2'd2; evCd = exitValue;
            end else if (testsPassed) begin
               evSt = 2'd1; evCd = 32'd0;
            end else if (maxCycles != 0 && mCnt >= maxCycles) begin
               evSt = 2'd3; evCd = 32'hFFFF_FFFF;
            end else begin
               evHit = 1'b0;
            end
            if (evHit) begin
               captured = 1'b1;
               capAge   = 0;
               mStatus  = evSt;
               mCode    = evCd;
            end else if (mCnt != '1) begin
               mCnt = mCnt + 1'b1;
            end
         end
         if (sinceRel < 1000000) sinceRel++;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (checkEn) begin
         checkOutput("core_rst_no", 32'(coreRstN), 32'(sinceRel >= RW));
         checkOutput("fetch_enable", 32'(fetchEn), 32'((sinceRel >= RW + 1) && !captured));
         checkOutput("cycle_cnt", cycleCnt, mCnt);
         checkOutput("status", 32'(status), 32'(mStatus));
         checkOutput("exit_code", exitCode, mCode);
         checkOutput("done", 32'(done), 32'(captured && capAge >= DW));
      end
   end

   task automatic applyStimulus(input logic passed, input logic failed, input logic exitV,
                                input logic [31:0] exitVal);
      testsPassed = passed;
      testsFailed = failed;
      exitValid   = exitV;
      exitValue   = exitVal;
   endtask

   task automatic applyReset();
      @(negedge clock);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic waitCnt(input logic [CW-1:0] target, input int budget);
      int n = 0;
      while (mCnt != target && n < budget) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (mCnt != target) begin
         errors++;
         $display("[TB] FAIL wait_cnt: got %0d, expected %0d within %0d cycles", mCnt, target, budget);
      end
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish before time limit");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      @(negedge clock);
      checkEn = 1'b1;

      // Reset release timing.
      applyReset();
      for (int k = 1; k <= 6; k++) begin
         @(negedge clock);
         checkOutput("rel_core_rst", 32'(coreRstN), 32'(k >= 4));
         checkOutput("rel_fetch", 32'(fetchEn), 32'(k >= 5));
         checkOutput("rel_cnt", cycleCnt, (k >= 5) ? 32'(k - 4) : 32'd0);
      end

      // Pass at run cycle 50, done exactly eight edges after capture.
      waitCnt(50, 100);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("pass_status", 32'(status), 32'd1);
      checkOutput("pass_code", exitCode, 32'd0);
      checkOutput("pass_fetch", 32'(fetchEn), 32'd0);
      repeat (7) @(negedge clock);
      checkOutput("pass_done_early", 32'(done), 32'd0);
      @(negedge clock);
      checkOutput("pass_done", 32'(done), 32'd1);
      checkOutput("pass_cnt", cycleCnt, 32'd50);

      // Nonzero exit; later events held high during drain must not overwrite.
      applyReset();
      waitCnt(20, 100);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd3);
      repeat (3) @(negedge clock);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'd5);
      repeat (9) @(negedge clock);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("exit_status", 32'(status), 32'd2);
      checkOutput("exit_code", exitCode, 32'd3);
      checkOutput("exit_done", 32'(done), 32'd1);
      checkOutput("exit_cnt", cycleCnt, 32'd20);

      // Priority: fail beats pass; exit beats pass.
      applyReset();
      waitCnt(7, 100);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("prio_fail_status", 32'(status), 32'd2);
      checkOutput("prio_fail_code", exitCode, 32'd1);
      applyReset();
      waitCnt(9, 100);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'd9);
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("prio_exit_status", 32'(status), 32'd2);
      checkOutput("prio_exit_code", exitCode, 32'd9);

      // Timeout at cycle_cnt 100.
      maxCycles = 100;
      applyReset();
      waitCnt(100, 200);
      @(negedge clock);
      checkOutput("tmo_status", 32'(status), 32'd3);
      checkOutput("tmo_code", exitCode, 32'hFFFF_FFFF);
      repeat (10) @(negedge clock);
      checkOutput("tmo_cnt", cycleCnt, 32'd100);
      checkOutput("tmo_done", 32'(done), 32'd1);

      // Budget lowered below the current count times out immediately.
      maxCycles = 0;
      applyReset();
      waitCnt(40, 100);
      maxCycles = 25;
      @(negedge clock);
      checkOutput("lower_status", 32'(status), 32'd3);
      checkOutput("lower_cnt", cycleCnt, 32'd40);

      // Unlimited budget.
      maxCycles = 0;
      applyReset();
      repeat (10004) @(negedge clock);
      checkOutput("unl_cnt", cycleCnt, 32'd10000);
      checkOutput("unl_status", 32'(status), 32'd0);
      checkOutput("unl_fetch", 32'(fetchEn), 32'd1);
      checkOutput("sat_cnt", 32'(smallCycleCnt), 32'd63);
      checkOutput("sat_status", 32'(smallStatus), 32'd0);

      // Mid-run reset and reset during drain.
      applyReset();
      waitCnt(30, 100);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkOutput("mid_core_rst", 32'(coreRstN), 32'd0);
      checkOutput("mid_fetch", 32'(fetchEn), 32'd0);
      checkOutput("mid_cnt", cycleCnt, 32'd0);
      waitCnt(5, 100);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkOutput("drain_rst_status", 32'(status), 32'd0);
      checkOutput("drain_rst_done", 32'(done), 32'd0);
      repeat (6) @(negedge clock);
      checkOutput("drain_rst_core", 32'(coreRstN), 32'd1);

      // Randomized runs checked by the model every cycle.
      for (int r = 0; r < 30; r++) begin
         maxCycles = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 250));
         applyReset();
         for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 199) == 0,
                          $urandom_range(0, 149) == 0,
                          ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 255)));
            if ($urandom_range(0, 249) == 0) maxCycles = 32'($urandom_range(0, 150));
            reset = ($urandom_range(0, 399) == 0);
         end
         reset = 1'b0;
      end

      @(negedge clock);
      checkEn = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
